motor_pwm_tx: RTL and testbench
===============================

MOTOR_PWM_TX -- requirements
Module: motor_pwm_tx

Interface
REQ-001 Parameter US_CYCLES, default 38: sys_clk cycles per microsecond tick.
REQ-002 Parameter FRAME_US, default 20000: PWM frame period in microseconds (50 Hz).
REQ-003 Parameter TIMEOUT_FRAMES, default 5: consecutive frames without a new command before failsafe.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 sys_clk  input  1  system clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 cmd_valid  input  1  motor command set offered.
REQ-008 cmd_ready  output  1  staging register empty, command will be accepted.
REQ-009 motor1_cmd..motor4_cmd  input  8 each  throttle command, unsigned, 0..250 meaningful.
REQ-010 armed  input  1  motors enabled; 0 forces minimum pulse.
REQ-011 pwm_out  output  4  ESC pulse outputs, bit i-1 drives motor i.
REQ-012 frame_start  output  1  one-cycle pulse on frame wrap.
REQ-013 failsafe  output  1  command timeout active.

Function
REQ-014 Prescaler SHALL count 0..US_CYCLES-1; us_tick asserted when prescaler = US_CYCLES-1.
REQ-015 frame_us SHALL increment on us_tick, wrapping FRAME_US-1 -> 0; wrap event = us_tick and frame_us = FRAME_US-1.
REQ-016 Handshake: command accepted when cmd_valid and cmd_ready are both high in one cycle; all four commands captured into staging, pending set.
REQ-017 cmd_ready SHALL equal not pending; commands offered while pending=1 are ignored and must be held by the sender.
REQ-018 On wrap event with pending=1: shadow registers load from staging, pending clears, timeout counter clears, failsafe clears.
REQ-019 Accept and wrap in the same cycle (pending=0): command goes to staging only; applied at the following wrap.
REQ-020 On wrap event with pending=0: timeout counter increments, saturating at TIMEOUT_FRAMES; shadow unchanged.
REQ-021 When timeout counter reaches TIMEOUT_FRAMES, failsafe SHALL assert from the next cycle and all effective commands read as 0 until REQ-018 clears it.
REQ-022 Effective command per motor = 0 if armed=0 or failsafe=1, else min(shadow, 250).
REQ-023 Pulse width per motor in microseconds = 1000 + 4 x effective command (range 1000..2000).
REQ-024 pwm_out[i] SHALL be registered: next value = (frame_us < width_i), giving one-cycle lag and high time exactly width_i x US_CYCLES cycles per frame.
REQ-025 Width changes (armed, failsafe, shadow) mid-frame take effect immediately in the compare; shadow itself only changes at wrap.
REQ-026 frame_start SHALL be registered high for exactly one cycle following each wrap event.

Reset
REQ-027 While rst=1: prescaler, frame_us, timeout counter = 0; staging, shadow = 0; pending = 0; pwm_out = 4'b0000; frame_start = 0; failsafe = 0; cmd_ready = 1.
REQ-028 rst asserted mid-frame SHALL abort the pulse; pwm_out low the cycle after rst is sampled; first new frame begins with frame_us = 0 after release.
REQ-029 A command accepted in the same cycle rst is high SHALL be discarded.

Verification
REQ-030 Reset release, armed=1, no command -> pwm_out = 4'b1111 for 1000 x US_CYCLES cycles, then low; frame_start every FRAME_US x US_CYCLES cycles.
REQ-031 Accept cmds 0/125/250/255 mid-frame, armed=1 -> current frame unchanged; next frame high times 1000/1500/2000/2000 us; cmd_ready low until that wrap.
REQ-032 Second cmd_valid held while pending -> not accepted until wrap; cmd_ready rises the cycle after wrap; accept then occurs.
REQ-033 Commands 200 each, then none for 5 frames -> failsafe high after 5th wrap; pulses 1000 us; new accepted command clears failsafe at next wrap.
REQ-034 armed dropped mid-pulse with cmd 250 at frame_us = 1200 -> pwm_out low within 2 cycles; rst at frame_us = 1500 -> all outputs 0, cmd_ready 1.
REQ-035 Accept coincident with wrap event -> values apply one frame later, no loss, no duplicate load.

Source files
------------

// File: rtl/motor_pwm_tx.sv
// Four-channel ESC pulse generator with a double-buffered command path.
// A microsecond prescaler drives a frame counter. Commands are accepted into
// a staging set at any time and are loaded into the shadow set only at the
// frame wrap, so a pulse never changes width because a command arrived.
// If no command arrives for TIMEOUT_FRAMES frames, the outputs fall back to
// minimum throttle until the next command is loaded.
module motor_pwm_tx #(
   parameter int US_CYCLES      = 38,
   parameter int FRAME_US       = 20000,
   parameter int TIMEOUT_FRAMES = 5
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] motor1_cmd,
   input  logic [7:0] motor2_cmd,
   input  logic [7:0] motor3_cmd,
   input  logic [7:0] motor4_cmd,
   input  logic       armed,
   output logic [3:0] pwm_out,
   output logic       frame_start,
   output logic       failsafe
);

   localparam int PW = (US_CYCLES > 1) ? $clog2(US_CYCLES) : 1;
   localparam int FW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
   // The compare needs room for the widest pulse (2000 us) as well as frame_us.
   localparam int CW = (FW > 11) ? FW : 11;
   localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

   logic [PW-1:0] prescaler_reg;
   logic [FW-1:0] frame_us_reg;
   logic [TW-1:0] timeout_reg;
   logic          pending_reg;
   logic          failsafe_reg;
   logic          frame_start_reg;
   logic [3:0]    pwm_reg;
   logic [3:0]    pwm_next;

   logic          us_tick;
   logic          wrap;
   logic          accept;
   logic          load;
   logic [CW-1:0] frame_ext;
   logic [7:0]    cmd_in [4];

   assign us_tick   = (prescaler_reg == PW'(US_CYCLES - 1));
   assign wrap      = us_tick && (frame_us_reg == FW'(FRAME_US - 1));
   assign accept    = cmd_valid && !pending_reg;
   assign load      = wrap && pending_reg;
   assign frame_ext = CW'(frame_us_reg);

   assign cmd_in[0] = motor1_cmd;
   assign cmd_in[1] = motor2_cmd;
   assign cmd_in[2] = motor3_cmd;
   assign cmd_in[3] = motor4_cmd;

   assign cmd_ready   = !pending_reg;
   assign failsafe    = failsafe_reg;
   assign frame_start = frame_start_reg;
   assign pwm_out     = pwm_reg;

   // Microsecond prescaler and frame position counter.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         prescaler_reg <= '0;
         frame_us_reg  <= '0;
      end else begin
         prescaler_reg <= us_tick ? '0 : prescaler_reg + 1'b1;
         if (us_tick) begin
            frame_us_reg <= wrap ? '0 : frame_us_reg + 1'b1;
         end
      end
   end

   // Pending flag: set by an accepted command, cleared when the wrap loads it.
   // accept requires pending=0 and load requires pending=1, so they never collide;
   // an accept coinciding with a wrap only stages the command.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         pending_reg <= 1'b0;
      end else if (load) begin
         pending_reg <= 1'b0;
      end else if (accept) begin
         pending_reg <= 1'b1;
      end
   end

   // Command timeout: counts wraps without a fresh command, saturating.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         timeout_reg  <= '0;
         failsafe_reg <= 1'b0;
      end else if (wrap) begin
         if (pending_reg) begin
            timeout_reg  <= '0;
            failsafe_reg <= 1'b0;
         end else begin
            if (timeout_reg != TW'(TIMEOUT_FRAMES)) begin
               timeout_reg <= timeout_reg + 1'b1;
            end
            if (timeout_reg >= TW'(TIMEOUT_FRAMES - 1)) begin
               failsafe_reg <= 1'b1;
            end
         end
      end
   end

   // Per-motor staging/shadow registers and pulse-width compare.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_motor
         logic [7:0]    staging_reg;
         logic [7:0]    shadow_reg;
         logic [7:0]    eff_cmd;
         logic [CW-1:0] width_us;

         // Staging captures on accept; shadow updates only at a loading wrap.
         always_ff @(posedge sys_clk) begin
            if (rst) begin
               staging_reg <= '0;
               shadow_reg  <= '0;
            end else begin
               if (accept) begin
                  staging_reg <= cmd_in[gi];
               end
               if (load) begin
                  shadow_reg <= staging_reg;
               end
            end
         end

         // Effective throttle reacts immediately to armed and failsafe.
         always_comb begin
            eff_cmd = 8'd0;
            if (armed && !failsafe_reg) begin
               eff_cmd = (shadow_reg > 8'd250) ? 8'd250 : shadow_reg;
            end
         end

         assign width_us     = CW'(1000) + CW'({eff_cmd, 2'b00});
         assign pwm_next[gi] = (frame_ext < width_us);
      end
   endgenerate

   // Registered outputs: pulse compare and the frame-start strobe.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         pwm_reg         <= 4'b0000;
         frame_start_reg <= 1'b0;
      end else begin
         pwm_reg         <= pwm_next;
         frame_start_reg <= wrap;
      end
   end

endmodule

// File: tb/tb_motor_pwm_tx.sv
// Directed bench for motor_pwm_tx using short frames: measures per-channel
// high time and frame length between frame_start strobes.
module tb_motor_pwm_tx;

   localparam int US  = 2;
   localparam int FR  = 2050;
   localparam int TO  = 3;
   localparam int P   = US * FR;

   logic       sys_clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] motor1_cmd, motor2_cmd, motor3_cmd, motor4_cmd;
   logic       armed;
   logic [3:0] pwm_out;
   logic       frame_start;
   logic       failsafe;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0][7:0] cmd;
      int              w [4];
   } vec_t;

   vec_t vecs [4];

   int cnt [4];
   int last_cnt [4];
   int len;
   int last_len;

   always #5 sys_clk = ~sys_clk;

   motor_pwm_tx #(.US_CYCLES(US), .FRAME_US(FR), .TIMEOUT_FRAMES(TO)) dut (
      .sys_clk(sys_clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .motor1_cmd(motor1_cmd),
      .motor2_cmd(motor2_cmd),
      .motor3_cmd(motor3_cmd),
      .motor4_cmd(motor4_cmd),
      .armed(armed),
      .pwm_out(pwm_out),
      .frame_start(frame_start),
      .failsafe(failsafe)
   );

   // Per-frame high-time and length monitor, sampled on the falling edge.
   always @(negedge sys_clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) cnt[i] <= 0;
         len <= 0;
      end else if (frame_start) begin
         for (int i = 0; i < 4; i++) begin
            last_cnt[i] <= cnt[i];
            cnt[i]      <= int'(pwm_out[i]);
         end
         last_len <= len;
         len      <= 1;
      end else begin
         for (int i = 0; i < 4; i++) cnt[i] <= cnt[i] + int'(pwm_out[i]);
         len <= len + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
      #1;
   endtask

   task automatic wait_fs();
      int n;
      n = 0;
      while (1) begin
         @(negedge sys_clk);
         n++;
         if (frame_start) break;
         if (n > P + 50) begin
            check("frame_start timeout", 0, 1);
            break;
         end
      end
      #1;
   endtask

   task automatic drive_cmd(input logic [3:0][7:0] c);
      motor1_cmd = c[0];
      motor2_cmd = c[1];
      motor3_cmd = c[2];
      motor4_cmd = c[3];
   endtask

   task automatic offer(input logic [3:0][7:0] c);
      int n;
      drive_cmd(c);
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready) begin
         tick(1);
         n++;
         if (n > P + 50) begin
            check("cmd_ready timeout", 0, 1);
            break;
         end
      end
      @(posedge sys_clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic check_widths(input string tag, input int w [4]);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s high cycles m%0d", tag, i + 1), last_cnt[i], w[i] * US);
      end
   endtask

   initial begin
      int prev [4];
      int w1000 [4];
      int w_a [4];
      int w_b [4];
      int w_c [4];
      int bad;
      int n;

      vecs[0].cmd = {8'd255, 8'd250, 8'd125, 8'd0};   vecs[0].w = '{1000, 1500, 2000, 2000};
      vecs[1].cmd = {8'd40, 8'd30, 8'd20, 8'd10};     vecs[1].w = '{1040, 1080, 1120, 1160};
      vecs[2].cmd = {8'd100, 8'd1, 8'd251, 8'd249};   vecs[2].w = '{1996, 2000, 1004, 1400};
      vecs[3].cmd = {8'd50, 8'd200, 8'd0, 8'd255};    vecs[3].w = '{2000, 1000, 1800, 1200};
      w1000 = '{1000, 1000, 1000, 1000};
      w_a   = '{1200, 1200, 1200, 1200};
      w_b   = '{1800, 1800, 1800, 1800};
      w_c   = '{2000, 2000, 2000, 2000};

      rst = 1'b1;
      cmd_valid = 1'b0;
      armed = 1'b1;
      drive_cmd('0);
      tick(3);
      check("reset pwm_out", int'(pwm_out), 0);
      check("reset frame_start", int'(frame_start), 0);
      check("reset failsafe", int'(failsafe), 0);
      check("reset cmd_ready", int'(cmd_ready), 1);
      rst = 1'b0;

      // First frame after reset with no command: minimum pulse on all channels.
      wait_fs();
      check_widths("initial", w1000);
      prev = w1000;

      // Table: each command applies one frame after acceptance.
      for (int k = 0; k < 4; k++) begin
         offer(vecs[k].cmd);
         tick(5);
         check($sformatf("vec%0d cmd_ready low while pending", k), int'(cmd_ready), 0);
         wait_fs();
         check($sformatf("vec%0d frame length", k), last_len, P);
         check_widths($sformatf("vec%0d current frame", k), prev);
         prev = vecs[k].w;
      end

      // A accepted, B held while pending; B accepted just after the wrap.
      offer({8'd50, 8'd50, 8'd50, 8'd50});
      drive_cmd({8'd200, 8'd200, 8'd200, 8'd200});
      cmd_valid = 1'b1;
      bad = 0;
      n = 0;
      while (1) begin
         tick(1);
         n++;
         if (frame_start) break;
         if (cmd_ready) bad++;
         if (n > P + 50) begin
            check("held cmd wrap timeout", 0, 1);
            break;
         end
      end
      check("cmd_ready low cycles while pending", bad, 0);
      check("cmd_ready high after wrap", int'(cmd_ready), 1);
      check_widths("vec3 applied", prev);
      @(posedge sys_clk);
      #1;
      cmd_valid = 1'b0;
      check("held cmd accepted after wrap", int'(cmd_ready), 0);

      wait_fs();
      check_widths("cmd A", w_a);
      check("failsafe after A", int'(failsafe), 0);
      wait_fs();
      check_widths("cmd B frame 1", w_b);
      wait_fs();
      check_widths("cmd B frame 2", w_b);
      check("failsafe before timeout", int'(failsafe), 0);

      // Command offered exactly in the wrap cycle that trips the timeout.
      tick(P - 1);
      check("ready in wrap cycle", int'(cmd_ready), 1);
      check("no frame_start in wrap cycle", int'(frame_start), 0);
      drive_cmd({8'd250, 8'd250, 8'd250, 8'd250});
      cmd_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      cmd_valid = 1'b0;
      tick(1);
      check("coincident frame_start", int'(frame_start), 1);
      check("failsafe after timeout", int'(failsafe), 1);
      check("coincident cmd pending", int'(cmd_ready), 0);
      check_widths("cmd B frame 3", w_b);

      wait_fs();
      check_widths("failsafe frame", w1000);
      check("failsafe cleared by load", int'(failsafe), 0);
      wait_fs();
      check_widths("cmd C", w_c);
      check("no duplicate pending", int'(cmd_ready), 1);

      // Disarm mid-pulse at frame_us = 1200.
      tick(1200 * US);
      check("pwm high at 1200us", int'(pwm_out), 15);
      armed = 1'b0;
      tick(2);
      check("pwm low after disarm", int'(pwm_out), 0);

      // Reset at frame_us = 1500 with a command offered during reset.
      tick(300 * US - 2);
      armed = 1'b1;
      drive_cmd({8'd250, 8'd250, 8'd250, 8'd250});
      cmd_valid = 1'b1;
      rst = 1'b1;
      tick(1);
      check("mid reset pwm_out", int'(pwm_out), 0);
      check("mid reset cmd_ready", int'(cmd_ready), 1);
      check("mid reset frame_start", int'(frame_start), 0);
      check("mid reset failsafe", int'(failsafe), 0);
      tick(1);
      rst = 1'b0;
      cmd_valid = 1'b0;
      tick(1);
      check("cmd during reset discarded", int'(cmd_ready), 1);
      wait_fs();
      check_widths("post reset", w1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
